// File: rtl/buzzer_arbiter.sv
// buzzer_arbiter: fixed-priority sharing of the buzzer between music and three SFX; define BUZZER_CHIRP_EN for an octave-up second half of each SFX
module buzzer_arbiter #(
  parameter logic [17:0] SFX0_HALF = 18'd47801,
  parameter logic [17:0] SFX1_HALF = 18'd63776,
  parameter logic [17:0] SFX2_HALF = 18'd75873,
  parameter logic [26:0] SFX_LEN   = 27'd5000000,
  parameter logic [26:0] GAP_CYC   = 27'd200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  game_state,
  input  logic [17:0] music_half,
  input  logic [2:0]  sfx_req,
  output logic [2:0]  sfx_ack,
  output logic        sfx_busy,
  output logic [1:0]  src_id,
  output logic        beep,
  output logic        sd
);
  typedef enum logic [1:0] {MUSIC, PLAY, GAP} state_t;
  state_t      state;
  logic [1:0]  cur;
  logic [26:0] dur;
  logic [26:0] gap;
  logic [17:0] cnt;
  logic [17:0] prev_half;
  logic [17:0] base_half;
  logic [17:0] sfx_half;
  logic [17:0] half;
  logic [2:0]  eff;
  logic [1:0]  lo;
  logic        can_grant;
  // Requests seen in the ack cycle are masked so a held request is not granted twice
  always_comb begin
    eff       = sfx_req & ~sfx_ack;
    lo        = eff[0] ? 2'd0 : eff[1] ? 2'd1 : 2'd2;
    can_grant = (|eff) && (game_state == 4'd1 || game_state == 4'd3);
    base_half = cur == 2'd0 ? SFX0_HALF : cur == 2'd1 ? SFX1_HALF : SFX2_HALF;
`ifdef BUZZER_CHIRP_EN
    sfx_half  = dur >= (SFX_LEN >> 1) ? base_half >> 1 : base_half;
`else
    sfx_half  = base_half;
`endif
    half      = game_state == 4'd0 ? 18'd0 :
                state == PLAY ? sfx_half :
                (state == MUSIC && game_state == 4'd1) ? music_half : 18'd0;
  end
  // Arbitration FSM: grant/preempt, SFX duration, silence gap, abort on game_state 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= MUSIC;
      cur      <= 2'd0;
      dur      <= 27'd0;
      gap      <= 27'd0;
      sfx_ack  <= 3'b000;
      sfx_busy <= 1'b0;
      src_id   <= 2'd0;
      sd       <= 1'b0;
    end else begin
      sd      <= game_state != 4'd0;
      sfx_ack <= 3'b000;
      if (game_state == 4'd0) begin
        state    <= MUSIC;
        src_id   <= 2'd0;
        sfx_busy <= 1'b0;
      end else if (can_grant && (state == MUSIC || (state == PLAY && lo < cur))) begin
        state    <= PLAY;
        cur      <= lo;
        dur      <= 27'd0;
        sfx_ack  <= 3'b001 << lo;
        src_id   <= lo + 2'd1;
        sfx_busy <= 1'b1;
      end else if (state == PLAY) begin
        dur <= dur + 27'd1;
        if (dur == SFX_LEN - 27'd1) begin
          state    <= (GAP_CYC == 27'd0) ? MUSIC : GAP;
          gap      <= 27'd0;
          src_id   <= 2'd0;
          sfx_busy <= 1'b0;
        end
      end else if (state == GAP) begin
        gap <= gap + 27'd1;
        if (gap == GAP_CYC - 27'd1) state <= MUSIC;
      end
    end
  end
  // Tone generator: reload on half change keeping the level, toggle every half cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      beep      <= 1'b0;
      cnt       <= 18'd0;
      prev_half <= 18'd0;
    end else begin
      prev_half <= half;
      if (half == 18'd0) begin
        beep <= 1'b0;
        cnt  <= 18'd0;
      end else if (half != prev_half) begin
        cnt <= 18'd0;
      end else if (cnt == half - 18'd1) begin
        beep <= ~beep;
        cnt  <= 18'd0;
      end else begin
        cnt <= cnt + 18'd1;
      end
    end
  end
endmodule

// File: tb/tb_buzzer_arbiter.sv
// tb_buzzer_arbiter: directed and random scenarios against a countdown/phase reference model
module tb_buzzer_arbiter;
  localparam int LEN  = 100;
  localparam int GAPC = 4;
  logic clk = 0, rst = 1;
  logic [3:0] gs = 0;
  logic [17:0] mh = 0;
  logic [2:0] req = 0, drop = 0;
  logic [2:0] sfx_ack;
  logic sfx_busy, beep, sd;
  logic [1:0] src_id;
  int errors = 0, checks = 0;
  int cyc = 0, m_mode = 0, m_owner = 0, m_left = 0, m_gap = 0, t0 = 0, mhalf = 0, m_prev = 0;
  logic m_beep = 0, b0 = 0, m_sd = 0, m_busy = 0;
  logic [1:0] m_src = 0;
  logic [2:0] m_ack = 0;
  int hv[3] = '{5, 7, 9};
  logic [7:0] got, want;
  assign got  = {beep, sd, sfx_busy, src_id, sfx_ack};
  assign want = {m_beep, m_sd, m_busy, m_src, m_ack};

  buzzer_arbiter #(.SFX0_HALF(18'd5), .SFX1_HALF(18'd7), .SFX2_HALF(18'd9),
                   .SFX_LEN(27'(LEN)), .GAP_CYC(27'(GAPC))) dut (
    .clk(clk), .rst(rst), .game_state(gs), .music_half(mh), .sfx_req(req),
    .sfx_ack(sfx_ack), .sfx_busy(sfx_busy), .src_id(src_id), .beep(beep), .sd(sd));

  always #5 clk = ~clk;

  // Reference: owner plus remaining-time countdowns; beep from phase arithmetic since last half change
  always @(posedge clk) begin : model
    int lo;
    logic [2:0] eff;
    cyc++;
    if (rst) begin
      m_mode = 0; m_owner = 0; m_beep = 0; m_prev = 0; m_sd = 0; m_busy = 0; m_src = 0; m_ack = 0;
    end else begin
      mhalf = (gs == 0 || m_mode == 2) ? 0 : m_mode == 1 ? hv[m_owner-1] : (gs == 1 ? int'(mh) : 0);
`ifdef BUZZER_CHIRP_EN
      if (m_mode == 1 && gs != 0 && LEN - m_left >= LEN / 2) mhalf = mhalf / 2;
`endif
      if (mhalf == 0) m_beep = 0;
      else begin
        if (mhalf != m_prev) begin t0 = cyc; b0 = m_beep; end
        m_beep = b0 ^ (((cyc - t0) / mhalf) % 2 == 1);
      end
      m_prev = mhalf;
      eff = req & ~m_ack;
      m_ack = 0;
      lo = eff[0] ? 1 : eff[1] ? 2 : eff[2] ? 3 : 0;
      if (gs == 0) m_mode = 0;
      else if (lo != 0 && (gs == 1 || gs == 3) && (m_mode == 0 || (m_mode == 1 && lo < m_owner))) begin
        m_mode = 1; m_owner = lo; m_left = LEN; m_ack = 3'(1 << (lo - 1));
      end else if (m_mode == 1) begin
        m_left--;
        if (m_left == 0) begin m_mode = (GAPC > 0) ? 2 : 0; m_gap = GAPC; end
      end else if (m_mode == 2) begin
        m_gap--;
        if (m_gap == 0) m_mode = 0;
      end
      m_sd = gs != 0;
      m_busy = m_mode == 1;
      m_src = m_mode == 1 ? 2'(m_owner) : 2'd0;
    end
  end

  // Requester behaviour: hold request through the ack cycle, drop it one cycle later
  task automatic step();
    @(negedge clk);
    req = req & ~drop;
    drop = sfx_ack;
  endtask

  task automatic test_reset();
    gs = 1; mh = 10;
    repeat (3) begin
      step();
      checks++;
      if (got !== 8'b0) begin errors++; $display("FAIL reset cyc=%0d got=%b want=00000000", cyc, got); end
    end
    rst = 0;
  endtask

  task automatic test_music();
    logic b;
    int n;
    b = beep;
    for (int k = 0; k < 25 && beep === b; k++) begin
      step();
      checks++;
      if (got !== want) begin errors++; $display("FAIL music cyc=%0d got=%b want=%b", cyc, got, want); end
    end
    b = beep;
    for (n = 0; n < 25; n++) begin
      step();
      checks++;
      if (got !== want) begin errors++; $display("FAIL music cyc=%0d got=%b want=%b", cyc, got, want); end
      if (beep !== b) break;
    end
    checks++;
    if (n + 1 != 10) begin errors++; $display("FAIL music_half_period got=%0d want=10", n + 1); end
  endtask

  task automatic test_sfx(input string name, input logic [2:0] r1, input int d1, input logic [2:0] r2, input int d2);
    req |= r1;
    repeat (d1) begin
      step();
      checks++;
      if (got !== want) begin errors++; $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, got, want); end
    end
    req |= r2;
    repeat (d2) begin
      step();
      checks++;
      if (got !== want) begin errors++; $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, got, want); end
    end
  endtask

  task automatic test_preempt_at_end();
    int k;
    req |= 3'b010;
    for (k = 0; k < 10 && sfx_ack !== 3'b010; k++) begin
      step();
      checks++;
      if (got !== want) begin errors++; $display("FAIL end_preempt cyc=%0d got=%b want=%b", cyc, got, want); end
    end
    checks++;
    if (sfx_ack !== 3'b010) begin errors++; $display("FAIL end_preempt_ack got=%b want=010", sfx_ack); end
    repeat (LEN - 1) begin
      step();
      checks++;
      if (got !== want) begin errors++; $display("FAIL end_preempt cyc=%0d got=%b want=%b", cyc, got, want); end
    end
    req |= 3'b001;
    repeat (120) begin
      step();
      checks++;
      if (got !== want) begin errors++; $display("FAIL end_preempt cyc=%0d got=%b want=%b", cyc, got, want); end
    end
  endtask

  task automatic test_halt();
    req |= 3'b100;
    repeat (20) step();
    gs = 2;
    test_sfx("halt", 3'b001, 150, 3'b000, 0);
    gs = 3;
    test_sfx("ending", 3'b000, 120, 3'b000, 0);
  endtask

  task automatic test_abort();
    gs = 1;
    test_sfx("abort_play", 3'b001, 20, 3'b000, 0);
    gs = 0;
    test_sfx("abort", 3'b010, 10, 3'b000, 0);
    gs = 1;
    test_sfx("abort_resume", 3'b000, 120, 3'b000, 0);
  endtask

  task automatic test_random();
    int r;
    repeat (1500) begin
      if ($urandom_range(19) == 0) req |= 3'(1 << $urandom_range(2));
      if ($urandom_range(149) == 0) begin
        r = $urandom_range(9);
        gs = r < 6 ? 4'd1 : r < 8 ? 4'd3 : r < 9 ? 4'd2 : 4'd0;
      end
      if ($urandom_range(59) == 0) mh = 18'($urandom_range(12));
      step();
      checks++;
      if (got !== want) begin errors++; $display("FAIL random cyc=%0d got=%b want=%b", cyc, got, want); end
    end
  endtask

  initial begin
    test_reset();
    test_music();
    test_sfx("sfx2", 3'b100, 130, 3'b000, 0);
    test_sfx("preempt", 3'b100, 30, 3'b001, 230);
    test_sfx("simul", 3'b011, 250, 3'b000, 0);
    test_preempt_at_end();
    test_halt();
    test_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
